dcache_snoop_bus: RTL and testbench

//  Bus/responder end of the Dcache coherence interface: arbitrates Dcache2bus requests from both cores, broadcasts the

---
 rtl/dcache_snoop_bus_pkg.sv | 18 +
 rtl/dcache_bus_arb.sv | 14 +
 rtl/dcache_snoop_bus.sv | 98 +++++++++
 tb/tb_dcache_snoop_bus.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_snoop_bus_pkg.sv
// dcache_snoop_bus_pkg: shared widths, message and state types for the Dcache snoop bus
`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 20
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 6
`endif
`ifndef DCACHE_WORD_IN_BITS
`define DCACHE_WORD_IN_BITS 64
`endif
package dcache_snoop_bus_pkg;
  localparam int DCACHE_TAG_W = `DCACHE_TAG_W;
  localparam int DCACHE_IDX_W = `DCACHE_IDX_W;
  localparam int DCACHE_DATA_W = `DCACHE_WORD_IN_BITS;
  localparam int MSG_W = 2;
  typedef enum logic [MSG_W-1:0] {MSG_NONE, MSG_GET_S, MSG_GET_M, MSG_PUT_M} message_t;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SNOOP, S_MEM_WR, S_MEM_RD, S_MEM_WAIT, S_RSP} bus_state_e;
endpackage

// File: rtl/dcache_bus_arb.sv
// dcache_bus_arb: 2-input round-robin arbiter with one-hot grant and pointer update on accept
module dcache_bus_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb gnt = ptr ? (req[1] ? 2'b10 : {1'b0, req[0]}) : (req[0] ? 2'b01 : {req[1], 1'b0});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (accept && |gnt) ptr <= gnt[0];
endmodule

// File: rtl/dcache_snoop_bus.sv
// dcache_snoop_bus: arbitrates core requests, snoops the peer, falls back to memory and returns the fill
module dcache_snoop_bus
  import dcache_snoop_bus_pkg::*;
#(
  parameter int NUM_CPU   = 2,
  parameter int TAG_W     = DCACHE_TAG_W,
  parameter int IDX_W     = DCACHE_IDX_W,
  parameter int DATA_W    = DCACHE_DATA_W,
  parameter int SNOOP_WIN = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CPU-1:0]        Dcache2bus_req_en_i,
  input  logic [NUM_CPU*TAG_W-1:0]  Dcache2bus_req_tag_i,
  input  logic [NUM_CPU*IDX_W-1:0]  Dcache2bus_req_idx_i,
  input  logic [NUM_CPU*DATA_W-1:0] Dcache2bus_req_data_i,
  input  logic [NUM_CPU*MSG_W-1:0]  Dcache2bus_req_message_i,
  input  logic [NUM_CPU-1:0]        Dcache2bus_rsp_vld_i,
  input  logic [NUM_CPU*DATA_W-1:0] Dcache2bus_rsp_data_i,
  input  logic [NUM_CPU-1:0]        Dcache2bus_rsp_ack_i,
  output logic [NUM_CPU-1:0]        bus2Dcache_req_ack_o,
  output logic                      bus2Dcache_req_id_o,
  output logic [TAG_W-1:0]          bus2Dcache_req_tag_o,
  output logic [IDX_W-1:0]          bus2Dcache_req_idx_o,
  output message_t                  bus2Dcache_req_message_o,
  output logic                      bus2Dcache_rsp_vld_o,
  output logic                      bus2Dcache_rsp_id_o,
  output logic [DATA_W-1:0]         bus2Dcache_rsp_data_o,
  output logic                      mem_req_en_o,
  output logic                      mem_req_wr_o,
  output logic [63:0]               mem_req_addr_o,
  output logic [DATA_W-1:0]         mem_req_data_o,
  input  logic                      mem_req_ack_i,
  input  logic                      mem_rsp_vld_i,
  input  logic [DATA_W-1:0]         mem_rsp_data_i
);
  localparam int CW = SNOOP_WIN > 1 ? $clog2(SNOOP_WIN) : 1;
  bus_state_e state, nxt;
  logic [1:0] gnt;
  logic gid, id_q, peer_vld, grant;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  message_t msg_q;
  logic [CW-1:0] cnt_q;
  dcache_bus_arb u_arb (.clk(clk), .rst_n(rst_n), .req(Dcache2bus_req_en_i), .accept(state == S_IDLE), .gnt(gnt));
  always_comb begin
    gid = gnt[1];
    peer_vld = Dcache2bus_rsp_vld_i[~id_q];
    grant = state == S_GRANT;
    nxt = state;
    case (state)
      S_IDLE:     nxt = |gnt ? S_GRANT : S_IDLE;
      S_GRANT:    nxt = msg_q == MSG_PUT_M ? S_MEM_WR : S_SNOOP;
      S_SNOOP:    nxt = peer_vld ? (msg_q == MSG_GET_S ? S_MEM_WR : S_RSP) : (cnt_q == CW'(SNOOP_WIN - 1) ? S_MEM_RD : S_SNOOP);
      S_MEM_WR:   nxt = !mem_req_ack_i ? S_MEM_WR : (msg_q == MSG_PUT_M ? S_IDLE : S_RSP);
      S_MEM_RD:   nxt = mem_req_ack_i ? S_MEM_WAIT : S_MEM_RD;
      S_MEM_WAIT: nxt = mem_rsp_vld_i ? S_RSP : S_MEM_WAIT;
      S_RSP:      nxt = Dcache2bus_rsp_ack_i[id_q] ? S_IDLE : S_RSP;
      default:    nxt = S_IDLE;
    endcase
    bus2Dcache_req_ack_o = NUM_CPU'(grant) << id_q;
    bus2Dcache_req_id_o = grant & id_q;
    bus2Dcache_req_tag_o = grant ? tag_q : '0;
    bus2Dcache_req_idx_o = grant ? idx_q : '0;
    bus2Dcache_req_message_o = grant ? msg_q : MSG_NONE;
    bus2Dcache_rsp_vld_o = state == S_RSP;
    bus2Dcache_rsp_id_o = bus2Dcache_rsp_vld_o & id_q;
    bus2Dcache_rsp_data_o = bus2Dcache_rsp_vld_o ? data_q : '0;
    mem_req_wr_o = state == S_MEM_WR;
    mem_req_en_o = mem_req_wr_o || state == S_MEM_RD;
    mem_req_addr_o = mem_req_en_o ? 64'({tag_q, idx_q, 3'b000}) : '0;
    mem_req_data_o = mem_req_wr_o ? data_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_q <= 1'b0;
      tag_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      msg_q <= MSG_NONE;
      cnt_q <= '0;
    end else begin
      if (state == S_IDLE && |gnt) begin
        id_q <= gid;
        tag_q <= Dcache2bus_req_tag_i[gid*TAG_W +: TAG_W];
        idx_q <= Dcache2bus_req_idx_i[gid*IDX_W +: IDX_W];
        data_q <= Dcache2bus_req_data_i[gid*DATA_W +: DATA_W];
        msg_q <= message_t'(Dcache2bus_req_message_i[gid*MSG_W +: MSG_W]);
      end
      cnt_q <= state == S_SNOOP ? cnt_q + 1'b1 : '0;
      if (state == S_SNOOP && peer_vld) data_q <= Dcache2bus_rsp_data_i[(~id_q)*DATA_W +: DATA_W];
      if (state == S_MEM_WAIT && mem_rsp_vld_i) data_q <= mem_rsp_data_i;
    end
endmodule

// File: tb/tb_dcache_snoop_bus.sv
// tb_dcache_snoop_bus: scoreboard bench for the Dcache snoop bus
module tb_dcache_snoop_bus;
  import dcache_snoop_bus_pkg::*;
  localparam int TW = DCACHE_TAG_W;
  localparam int IW = DCACHE_IDX_W;
  localparam int DW = DCACHE_DATA_W;
  logic clk = 0, rst_n = 0;
  logic [1:0] req_en = 0, rsp_vld_in = 0, rsp_ack_in = 0, ack_out;
  logic [2*TW-1:0] req_tag = 0;
  logic [2*IW-1:0] req_idx = 0;
  logic [2*DW-1:0] req_data = 0, rsp_data_in = 0;
  logic [2*MSG_W-1:0] req_msg = 0;
  logic req_id_out, rsp_vld_out, rsp_id_out, mem_en, mem_wr;
  logic [TW-1:0] tag_out;
  logic [IW-1:0] idx_out;
  message_t msg_out;
  logic [DW-1:0] rsp_data_out, mem_wdata, mem_rdata = 0;
  logic [63:0] mem_addr;
  logic mem_ack = 0, mem_rvld = 0;
  always #5 clk = ~clk;
  dcache_snoop_bus dut (
    .clk(clk), .rst_n(rst_n),
    .Dcache2bus_req_en_i(req_en), .Dcache2bus_req_tag_i(req_tag), .Dcache2bus_req_idx_i(req_idx),
    .Dcache2bus_req_data_i(req_data), .Dcache2bus_req_message_i(req_msg),
    .Dcache2bus_rsp_vld_i(rsp_vld_in), .Dcache2bus_rsp_data_i(rsp_data_in), .Dcache2bus_rsp_ack_i(rsp_ack_in),
    .bus2Dcache_req_ack_o(ack_out), .bus2Dcache_req_id_o(req_id_out), .bus2Dcache_req_tag_o(tag_out),
    .bus2Dcache_req_idx_o(idx_out), .bus2Dcache_req_message_o(msg_out),
    .bus2Dcache_rsp_vld_o(rsp_vld_out), .bus2Dcache_rsp_id_o(rsp_id_out), .bus2Dcache_rsp_data_o(rsp_data_out),
    .mem_req_en_o(mem_en), .mem_req_wr_o(mem_wr), .mem_req_addr_o(mem_addr), .mem_req_data_o(mem_wdata),
    .mem_req_ack_i(mem_ack), .mem_rsp_vld_i(mem_rvld), .mem_rsp_data_i(mem_rdata)
  );
  typedef struct packed {logic [1:0] ack; logic id; logic [TW-1:0] tag; logic [IW-1:0] idx; logic [1:0] msg;} gexp_t;
  typedef struct packed {logic wr; logic [63:0] addr; logic [DW-1:0] data;} mexp_t;
  typedef struct packed {logic id; logic [DW-1:0] data;} rexp_t;
  gexp_t gq[$];
  mexp_t mq[$];
  rexp_t rq[$];
  gexp_t g;
  mexp_t m;
  rexp_t r;
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic exp_g(input logic [1:0] ack, input logic id, input logic [TW-1:0] tag, input logic [IW-1:0] idx, input message_t msg);
    gq.push_back('{ack: ack, id: id, tag: tag, idx: idx, msg: msg});
  endtask
  task automatic exp_m(input logic wr, input logic [63:0] addr, input logic [DW-1:0] data);
    mq.push_back('{wr: wr, addr: addr, data: data});
  endtask
  task automatic exp_r(input logic id, input logic [DW-1:0] data);
    rq.push_back('{id: id, data: data});
  endtask
  logic [1:0] prev_ack = 0;
  int run = 0, last_run = 0;
  always @(negedge clk) begin
    if (|ack_out) begin
      chk("ack_one_cycle", 64'(prev_ack), 0);
      if (gq.size() == 0) chk("grant_unexpected", 64'(ack_out), 0);
      else begin
        g = gq.pop_front();
        chk("grant_ack", 64'(ack_out), 64'(g.ack));
        chk("grant_id", 64'(req_id_out), 64'(g.id));
        chk("grant_tag", 64'(tag_out), 64'(g.tag));
        chk("grant_idx", 64'(idx_out), 64'(g.idx));
        chk("grant_msg", 64'(msg_out), 64'(g.msg));
      end
    end
    prev_ack = ack_out;
    run = mem_en ? run + 1 : 0;
    if (mem_en && mem_ack) begin
      last_run = run;
      run = 0;
      if (mq.size() == 0) chk("mem_unexpected", 64'(mem_en), 0);
      else begin
        m = mq.pop_front();
        chk("mem_wr", 64'(mem_wr), 64'(m.wr));
        chk("mem_addr", mem_addr, m.addr);
        if (m.wr) chk("mem_wdata", 64'(mem_wdata), 64'(m.data));
      end
    end
    if (rsp_vld_out && rsp_ack_in[rsp_id_out]) begin
      if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_vld_out), 0);
      else begin
        r = rq.pop_front();
        chk("rsp_id", 64'(rsp_id_out), 64'(r.id));
        chk("rsp_data", 64'(rsp_data_out), 64'(r.data));
      end
    end
  end
  logic supply = 0, own_junk = 0, pend_rd = 0, in_grant = 0, owner = 0;
  logic [DW-1:0] supply_data = 0;
  int mem_delay = 1, acnt = 0;
  always @(posedge clk) begin
    #1;
    rsp_vld_in = 0;
    mem_rvld = 0;
    if (!rst_n) begin
      pend_rd = 0;
      in_grant = 0;
      acnt = 0;
      mem_ack = 0;
      rsp_ack_in = 0;
    end else begin
      if (in_grant && supply) begin
        rsp_vld_in[~owner] = 1;
        rsp_data_in[(owner ? 0 : 1)*DW +: DW] = supply_data;
      end
      if (in_grant && own_junk) begin
        rsp_vld_in[owner] = 1;
        rsp_data_in[(owner ? 1 : 0)*DW +: DW] = 'hBAD;
      end
      in_grant = |ack_out;
      owner = req_id_out;
      if (pend_rd) begin
        mem_rvld = 1;
        pend_rd = 0;
      end
      if (mem_en) begin
        acnt++;
        mem_ack = acnt >= mem_delay;
        if (mem_ack && !mem_wr) pend_rd = 1;
      end else begin
        acnt = 0;
        mem_ack = 0;
      end
      rsp_ack_in = 0;
      if (rsp_vld_out) rsp_ack_in[rsp_id_out] = 1;
    end
  end
  task automatic request(input int c, input logic [TW-1:0] tag, input logic [IW-1:0] idx, input logic [DW-1:0] data, input message_t msg);
    int n = 0;
    @(posedge clk);
    #1;
    req_tag[c*TW +: TW] = tag;
    req_idx[c*IW +: IW] = idx;
    req_data[c*DW +: DW] = data;
    req_msg[c*MSG_W +: MSG_W] = msg;
    req_en[c] = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_out[c] && n < 300);
    if (n >= 300) chk("req_ack_timeout", 64'(ack_out[c]), 1);
    @(posedge clk);
    #1;
    req_en[c] = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (gq.size() + mq.size() + rq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 64'(gq.size() + mq.size() + rq.size()), 0);
    repeat (4) @(negedge clk);
  endtask
  task automatic chk_quiet(input string pfx);
    chk({pfx, "_ack"}, 64'(ack_out), 0);
    chk({pfx, "_msg"}, 64'(msg_out), 64'(MSG_NONE));
    chk({pfx, "_rsp_vld"}, 64'(rsp_vld_out), 0);
    chk({pfx, "_rsp_data"}, 64'(rsp_data_out), 0);
    chk({pfx, "_mem_en"}, 64'(mem_en), 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1;
    own_junk = 1;
    mem_rdata = 64'hDEAD_BEEF;
    exp_g(2'b01, 0, 20'h12, 6'd3, MSG_GET_S);
    exp_m(0, 64'h2418, 0);
    exp_r(0, 64'hDEAD_BEEF);
    request(0, 20'h12, 6'd3, 0, MSG_GET_S);
    drain();
    own_junk = 0;
    supply = 1;
    supply_data = 64'hA5A5;
    exp_g(2'b10, 1, 20'h34, 6'd5, MSG_GET_M);
    exp_r(1, 64'hA5A5);
    request(1, 20'h34, 6'd5, 0, MSG_GET_M);
    drain();
    supply_data = 64'h77;
    exp_g(2'b01, 0, 20'h01, 6'h3F, MSG_GET_S);
    exp_m(1, 64'h3F8, 64'h77);
    exp_r(0, 64'h77);
    request(0, 20'h01, 6'h3F, 0, MSG_GET_S);
    drain();
    supply = 0;
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    mem_rdata = 64'hC0DE;
    for (int i = 0; i < 2; i++) begin
      exp_g(2'b01, 0, 20'h20, 6'd1, MSG_GET_S);
      exp_m(0, 64'h4008, 0);
      exp_r(0, 64'hC0DE);
      exp_g(2'b10, 1, 20'h21, 6'd2, MSG_GET_S);
      exp_m(0, 64'h4210, 0);
      exp_r(1, 64'hC0DE);
      fork
        request(0, 20'h20, 6'd1, 0, MSG_GET_S);
        request(1, 20'h21, 6'd2, 0, MSG_GET_S);
      join
      drain();
    end
    mem_delay = 3;
    exp_g(2'b10, 1, 20'hAB, 6'd1, MSG_PUT_M);
    exp_m(1, 64'h15608, 64'h55);
    request(1, 20'hAB, 6'd1, 64'h55, MSG_PUT_M);
    drain();
    chk("putm_hold_cycles", 64'(last_run), 3);
    chk_quiet("putm_idle");
    mem_delay = 1000;
    exp_g(2'b01, 0, 20'h12, 6'd3, MSG_GET_S);
    request(0, 20'h12, 6'd3, 0, MSG_GET_S);
    n = 0;
    while (!mem_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rd_wait_timeout", 64'(mem_en), 1);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    chk_quiet("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    mem_delay = 1;
    mem_rdata = 64'hBEEF;
    exp_g(2'b10, 1, 20'h5, 6'd2, MSG_GET_S);
    exp_m(0, 64'hA10, 0);
    exp_r(1, 64'hBEEF);
    request(1, 20'h5, 6'd2, 0, MSG_GET_S);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
